// File: rtl/display_pkg.sv
// display_pkg
// Shared definitions for the display output stage: serializer FSM states,
// frame geometry, segment bit positions within a digit byte, and the helper
// that derives the shift-clock half period from the clock frequencies.
// No ports (package).
package display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    localparam int unsigned FRAME_BITS = 32;
    localparam int unsigned DIGIT_BITS = 8;

    // Bit positions inside one digit byte: {dp,g,f,e,d,c,b,a}
    localparam int unsigned SEG_A  = 0;
    localparam int unsigned SEG_B  = 1;
    localparam int unsigned SEG_C  = 2;
    localparam int unsigned SEG_D  = 3;
    localparam int unsigned SEG_E  = 4;
    localparam int unsigned SEG_F  = 5;
    localparam int unsigned SEG_G  = 6;
    localparam int unsigned SEG_DP = 7;

    // Half period of the shift clock in system cycles, truncated, never below 1.
    function automatic int unsigned calc_half(input int unsigned sys_hz,
                                              input int unsigned shift_hz);
        int unsigned h;
        h = sys_hz / (2 * shift_hz);
        return (h == 0) ? 1 : h;
    endfunction

endpackage

// File: rtl/serial_tick_gen.sv
// serial_tick_gen
// Half-period counter for the serializer. Held at zero while clear_i is high
// (serializer idle); otherwise counts and raises tick_o for one cycle every
// HALF cycles, wrapping to zero so each FSM state starts from a fresh count.
// Ports:
//   clk_i    system clock
//   rst_i    asynchronous active-high reset
//   clear_i  hold counter at zero, suppress tick
//   tick_o   one-cycle pulse at the end of each half period
module serial_tick_gen #(
    parameter int unsigned HALF = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CW = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF - 1);

    logic [CW-1:0] cnt_q;

    assign tick_o = !clear_i && (cnt_q == LAST);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/display_serializer.sv
// display_serializer
// Shifts a 32-bit frame of four 7-segment digit bytes out MSB first to
// 74HC595-style shift registers, then pulses the storage latch.
// Each bit: HALF cycles with shift clock low (data set up), HALF cycles high.
// Optional build macro DISPLAY_COMMON_ANODE_EN: invert the frame at capture
// for common-anode displays (idle/latch data still driven low).
// Ports:
//   i_clk           system clock
//   i_reset         asynchronous active-high reset
//   i_en            enable; low aborts a frame and holds idle
//   i_start         one-cycle frame request, honoured only when idle
//   i_data          frame, [31:24] digit 0 ... [7:0] digit 3
//   o_busy          frame in progress
//   o_done          one-cycle pulse after the latch phase
//   o_serial_data   serial data to shift register
//   o_serial_latch  storage-register latch
//   o_serial_clk    shift clock (external register samples on rise)
module display_serializer
    import display_pkg::*;
#(
    parameter int unsigned SYS_CLK_HZ   = 5_000_000,
    parameter int unsigned SHIFT_CLK_HZ = 1_000_000
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_en,
    input  logic                  i_start,
    input  logic [FRAME_BITS-1:0] i_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_serial_data,
    output logic                  o_serial_latch,
    output logic                  o_serial_clk
);

    localparam int unsigned HALF = calc_half(SYS_CLK_HZ, SHIFT_CLK_HZ);
    localparam int unsigned BW   = $clog2(FRAME_BITS);

    state_t                state_q;
    logic [FRAME_BITS-1:0] shreg_q;
    logic [BW-1:0]         bit_cnt_q;
    logic [FRAME_BITS-1:0] capture;
    logic                  tick;
    logic                  tick_clear;

`ifdef DISPLAY_COMMON_ANODE_EN
    assign capture = ~i_data;
`else
    assign capture = i_data;
`endif

    // Counter restarts from zero whenever a frame begins from idle.
    assign tick_clear = (state_q == IDLE);

    serial_tick_gen #(
        .HALF (HALF)
    ) u_tick_gen (
        .clk_i   (i_clk),
        .rst_i   (i_reset),
        .clear_i (tick_clear),
        .tick_o  (tick)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q        <= IDLE;
            shreg_q        <= '0;
            bit_cnt_q      <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_serial_data  <= 1'b0;
            o_serial_clk   <= 1'b0;
            o_serial_latch <= 1'b0;
        end else if (!i_en) begin
            // Abort: no latch, so the external register keeps its old contents.
            state_q        <= IDLE;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_serial_data  <= 1'b0;
            o_serial_clk   <= 1'b0;
            o_serial_latch <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start) begin
                        shreg_q       <= capture;
                        bit_cnt_q     <= BW'(FRAME_BITS - 1);
                        o_serial_data <= capture[FRAME_BITS-1];
                        o_serial_clk  <= 1'b0;
                        o_busy        <= 1'b1;
                        state_q       <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (tick) begin
                        o_serial_clk <= 1'b1;
                        state_q      <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        o_serial_clk <= 1'b0;
                        if (bit_cnt_q == '0) begin
                            o_serial_data  <= 1'b0;
                            o_serial_latch <= 1'b1;
                            state_q        <= LATCH;
                        end else begin
                            // Rotate rather than shift; only the upper bits matter.
                            shreg_q       <= {shreg_q[FRAME_BITS-2:0], shreg_q[FRAME_BITS-1]};
                            bit_cnt_q     <= bit_cnt_q - 1'b1;
                            o_serial_data <= shreg_q[FRAME_BITS-2];
                            state_q       <= SHIFT_LO;
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        o_serial_latch <= 1'b0;
                        o_busy         <= 1'b0;
                        o_done         <= 1'b1;
                        state_q        <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_serializer.sv
// tb_display_serializer
// Directed + randomized checks of display_serializer against a closed-form
// cycle model: for a frame started at cycle s, cycle c falls at offset
// k = c-s-1; bit k/(2H) is on the wire, clock high in the second half,
// latch for the H cycles after 64H, done at 65H+1.
module tb_display_serializer;

    localparam int unsigned SYS_HZ   = 5_000_000;
    localparam int unsigned SHIFT_HZ = 1_000_000;
    localparam int H = ((SYS_HZ / (2 * SHIFT_HZ)) < 1) ? 1 : int'(SYS_HZ / (2 * SHIFT_HZ));

    logic        clk = 1'b0;
    logic        i_reset, i_en, i_start;
    logic [31:0] i_data;
    logic        o_busy, o_done, o_serial_data, o_serial_latch, o_serial_clk;

    int errors = 0;
    int checks = 0;

    // Plan of the current observation window
    int          p_start[$];
    logic [31:0] p_word[$];
    int          p_abort[$];
    int          spur_cyc, en_low_cyc, en_high_cyc;
    logic [63:0] last_stream;

    display_serializer #(
        .SYS_CLK_HZ   (SYS_HZ),
        .SHIFT_CLK_HZ (SHIFT_HZ)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_en           (i_en),
        .i_start        (i_start),
        .i_data         (i_data),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_serial_data  (o_serial_data),
        .o_serial_latch (o_serial_latch),
        .o_serial_clk   (o_serial_clk)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] outs();
        return {o_busy, o_done, o_serial_data, o_serial_clk, o_serial_latch};
    endfunction

    function automatic logic [31:0] wire_word(input logic [31:0] w);
`ifdef DISPLAY_COMMON_ANODE_EN
        return ~w;
`else
        return w;
`endif
    endfunction

    // Expected {busy,done,data,clk,latch} at cycle c
    function automatic logic [4:0] model(input int c);
        logic [4:0]  e;
        logic [31:0] ww;
        int          s, last, k, b;
        e = '0;
        for (int i = 0; i < p_start.size(); i++) begin
            s    = p_start[i];
            last = (p_abort[i] >= 0) ? p_abort[i] : s + 65 * H;
            if (c > s && c <= last) begin
                e[4] = 1'b1;
                k    = c - s - 1;
                if (k < 64 * H) begin
                    b    = k / (2 * H);
                    ww   = wire_word(p_word[i]);
                    e[2] = ww[31-b];
                    e[1] = (k % (2 * H)) >= H;
                end else begin
                    e[0] = 1'b1;
                end
            end
            if (p_abort[i] < 0 && c == s + 1 + 65 * H) e[3] = 1'b1;
        end
        return e;
    endfunction

    task automatic clear_plan();
        p_start.delete();
        p_word.delete();
        p_abort.delete();
        spur_cyc    = -1;
        en_low_cyc  = -1;
        en_high_cyc = -1;
    endtask

    task automatic add_frame(input int s, input logic [31:0] w, input int ab);
        p_start.push_back(s);
        p_word.push_back(w);
        p_abort.push_back(ab);
    endtask

    // Frame 0 is requested at cycle 0; cycles 1..ncyc are compared and collected.
    task automatic observe(input string name, input int ncyc);
        logic [4:0]  got, exp;
        logic        pcd, pce, pld, ple;
        logic [63:0] sd, se;
        int          nd, ne, ld, le, lcd, lce, dd, de, fd, fe;
        pcd = 0; pce = 0; pld = 0; ple = 0; sd = '0; se = '0;
        nd = 0; ne = 0; ld = 0; le = 0; lcd = 0; lce = 0; dd = 0; de = 0; fd = -1; fe = -1;
        i_start = 1'b1;
        i_data  = p_word[0];
        tick();
        i_start = 1'b0;
        i_data  = $urandom;
        for (int c = 1; c <= ncyc; c++) begin
            got = outs();
            exp = model(c);
            chk($sformatf("%s outs@%0d", name, c), 64'(got), 64'(exp));
            if (got[1] && !pcd) begin sd = {sd[62:0], got[2]}; nd++; end
            if (exp[1] && !pce) begin se = {se[62:0], exp[2]}; ne++; end
            if (got[0] && !pld) ld++;
            if (exp[0] && !ple) le++;
            if (got[0]) lcd++;
            if (exp[0]) lce++;
            if (got[3]) begin dd++; if (fd < 0) fd = c; end
            if (exp[3]) begin de++; if (fe < 0) fe = c; end
            pcd = got[1]; pce = exp[1]; pld = got[0]; ple = exp[0];
            i_start = 1'b0;
            i_data  = $urandom;
            for (int i = 1; i < p_start.size(); i++) begin
                if (p_start[i] == c) begin i_start = 1'b1; i_data = p_word[i]; end
            end
            if (c == spur_cyc)    i_start = 1'b1;
            if (c == en_low_cyc)  i_en = 1'b0;
            if (c == en_high_cyc) i_en = 1'b1;
            tick();
        end
        chk({name, " edges"}, 64'(nd), 64'(ne));
        chk({name, " stream"}, sd, se);
        chk({name, " latches"}, 64'(ld), 64'(le));
        chk({name, " latch_cycles"}, 64'(lcd), 64'(lce));
        chk({name, " dones"}, 64'(dd), 64'(de));
        chk({name, " first_done"}, 64'(fd), 64'(fe));
        last_stream = sd;
    endtask

    initial begin
        i_reset = 1'b1;
        i_en    = 1'b1;
        i_start = 1'b0;
        i_data  = '0;
        #2;
        chk("reset outs", 64'(outs()), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            chk($sformatf("idle outs@%0d", c), 64'(outs()), 64'(0));
        end

        // Single frame, spurious start while busy at cycle 40
        clear_plan();
        add_frame(0, 32'hA5C3_0F81, -1);
        spur_cyc = 40;
        observe("single", 140);
        chk("single const", last_stream, 64'(wire_word(32'hA5C3_0F81)));

        // Back-to-back: second request in the done cycle
        clear_plan();
        add_frame(0, $urandom, -1);
        add_frame(1 + 65 * H, 32'h0000_00FF, -1);
        observe("b2b", 270);

        // Abort mid-frame, then a full frame
        clear_plan();
        add_frame(0, $urandom, 50);
        en_low_cyc  = 50;
        en_high_cyc = 60;
        observe("abort", 80);
        clear_plan();
        add_frame(0, $urandom, -1);
        observe("after_abort", 140);

        // Segment-polarity pattern
        clear_plan();
        add_frame(0, 32'hFFFF_0000, -1);
        observe("polarity", 140);
`ifdef DISPLAY_COMMON_ANODE_EN
        chk("polarity const", last_stream, 64'h0000_FFFF);
`else
        chk("polarity const", last_stream, 64'hFFFF_0000);
`endif

        // Random frames
        for (int r = 0; r < 3; r++) begin
            clear_plan();
            add_frame(0, $urandom, -1);
            observe($sformatf("rand%0d", r), 135);
        end

        // Asynchronous reset mid-frame
        i_start = 1'b1;
        i_data  = $urandom;
        tick();
        i_start = 1'b0;
        repeat (20) tick();
        chk("pre-reset busy", 64'(o_busy), 64'(1));
        i_reset = 1'b1;
        #1;
        chk("async reset outs", 64'(outs()), 64'(0));
        repeat (2) tick();
        i_reset = 1'b0;
        for (int c = 0; c < 200; c++) begin
            tick();
            chk($sformatf("post-reset outs@%0d", c), 64'(outs()), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_serializer.md
# display_serializer

Output stage of the digital clock: converts a 32-bit frame of four 7-segment digit patterns (8 bits per digit incl. decimal point) into a bit-serial stream for external 74HC595-style shift registers. It drives the serial data, shift clock and latch pins that the top level routes to `uo_out[2:0]`. The frame-formatting logic upstream requests one frame at a time with a start pulse.

## Interface
- `SYS_CLK_HZ`, 5_000_000, system clock frequency.
- `SHIFT_CLK_HZ`, 1_000_000, target serial clock frequency; half-period `HALF = max(1, SYS_CLK_HZ / (2*SHIFT_CLK_HZ))`, integer-truncated (default HALF=2, actual 1.25 MHz).

Ports:
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_reset`  in  1  reset, asynchronous, active-high.
- `i_en`  in  1  design enable; low aborts/holds idle.
- `i_start`  in  1  one-cycle frame request; sampled only in IDLE.
- `i_data`  in  32  frame; `[31:24]` digit 0 (hours tens) … `[7:0]` digit 3; bit order within digit `{dp,g,f,e,d,c,b,a}`.
- `o_busy`  out  1  frame in progress.
- `o_done`  out  1  one-cycle pulse after latch completes.
- `o_serial_data`  out  1  serial data, MSB first.
- `o_serial_latch`  out  1  storage-register latch, active-high.
- `o_serial_clk`  out  1  shift clock; external register samples on rising edge.

## Operation
- States: IDLE, SHIFT_LO, SHIFT_HI, LATCH.
- Reset: state IDLE; shift register 0; bit counter 0; all outputs 0.
- IDLE: if `i_en && i_start`, capture `i_data` into shift register, bit counter=31, half-period counter=0, go SHIFT_LO. Otherwise, remain in IDLE.
- SHIFT_LO (HALF cycles): `o_serial_clk=0`, `o_serial_data`=shift register MSB; then go SHIFT_HI.
- SHIFT_HI (HALF cycles): `o_serial_clk=1`, data held stable. On exit, if bit counter=0 go LATCH. Otherwise, shift left 1, decrement counter, go SHIFT_LO.
- LATCH (HALF cycles): `o_serial_clk=0`, `o_serial_data=0`, `o_serial_latch=1`; on exit go IDLE and pulse `o_done`.
- `o_busy`=1 in every state except IDLE.
- `i_start` while busy: ignored, not queued.
- `i_en` falling mid-frame: next cycle IDLE, all serial outputs 0, no `o_done`. The external register keeps its previous latched value.
- `i_data` changes after capture: no effect on the current frame.
- Async reset mid-frame: immediate return to reset values; no latch pulse.

## Timing
- Start sampled at cycle 0. Cycle 1 onward: `o_busy=1` and bit 31 on `o_serial_data`.
- Each bit occupies 2·HALF cycles: HALF low, then HALF high. The rising edge falls HALF cycles after the data change, giving setup = HALF cycles and hold = HALF cycles.
- Busy duration = 64·HALF + HALF = 65·HALF cycles (130 at default).
- `o_done` is high at cycle 1 + 65·HALF (131 at default), with `o_busy=0` in the same cycle.
- Back-to-back: `i_start` in the `o_done` cycle is accepted; the next frame's first bit appears one cycle later.
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- `DISPLAY_COMMON_ANODE_EN`
  - Defined: `i_data` is bitwise inverted at capture, so idle-low segments appear as high on the wire for common-anode displays. `o_serial_data` is still 0 in IDLE and LATCH.
  - Undefined: data is shifted as given (common cathode).

## Structure
- Shared package `display_pkg`: state enum (`IDLE`, `SHIFT_LO`, `SHIFT_HI`, `LATCH`), `FRAME_BITS = 32`, `DIGIT_BITS = 8`, segment-bit index constants.
- Sub-module `serial_tick_gen`: half-period counter. It is cleared on state entry and produces a one-cycle `tick` after HALF cycles. The FSM advances only on `tick`.

## Test plan
- Reset then idle: `i_reset=1` mid-frame → all outputs 0 immediately. After release with no start, outputs stay 0 for 200 cycles.
- Single frame, `i_data=32'hA5C3_0F81`, HALF=2 → 32 rising edges of `o_serial_clk`. Bits sampled at those edges equal A5C30F81 MSB first. One latch pulse of 2 cycles. `o_done` at cycle 131.
- Start while busy: `i_start` pulsed at cycle 40 → ignored; exactly 32 clocks and one latch.
- Back-to-back: second start (`32'h0000_00FF`) coincident with `o_done` → second frame's first bit at `o_done`+1; total 64 clock edges, 2 latches.
- Abort: `i_en` low at cycle 50 → next cycle IDLE, no latch, no `o_done`. A later start with `i_en=1` runs a full frame.
- Macro `DISPLAY_COMMON_ANODE_EN` defined, `i_data=32'hFFFF_0000` → sampled stream 0x0000FFFF.
